// File: rtl/perf_monitor.sv
// perf_monitor: cycle and per-channel event counters with saturation, a run FSM
// that stops after a programmable cycle limit, and a snapshot/select readout port.
module perf_monitor #(
   parameter int  NUM_EVENTS  = 4,
   parameter int  CNT_W       = 32,
   parameter int  CYCLE_LIMIT = 30,
   localparam int SEL_W       = $clog2(NUM_EVENTS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic                  clear_i,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic                  snap_i,
   input  logic [SEL_W-1:0]      sel_i,
   output logic [CNT_W-1:0]      count_o,
   output logic [CNT_W-1:0]      cycle_o,
   output logic [NUM_EVENTS-1:0] ovf_o,
   output logic                  running_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [31:0]      LIMIT   = 32'(CYCLE_LIMIT);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cyc_q;
   logic [CNT_W-1:0]      cyc_inc;
   logic [CNT_W-1:0]      ev_cnt_q [NUM_EVENTS];
   logic [NUM_EVENTS-1:0] ovf_q;
   logic [CNT_W-1:0]      snap_q [NUM_EVENTS+1];
   logic [CNT_W-1:0]      rd_val;
   logic                  counted;
   logic                  limit_hit;

   assign counted   = (state_q == S_RUN) && start_i;
   assign cyc_inc   = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
   assign limit_hit = (CYCLE_LIMIT != 0) && (32'(cyc_inc) == LIMIT);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_RUN;
         S_RUN:   if (counted && limit_hit) state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (clear_i) state_d = S_IDLE;
   end

   // NOTE: non-blocking updates here are what let the snapshot block below see the
   // pre-increment counter values on the same edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cyc_q <= '0;
         ovf_q <= '0;
         for (int k = 0; k < NUM_EVENTS; k++) ev_cnt_q[k] <= '0;
      end else if (clear_i) begin
         cyc_q <= '0;
         ovf_q <= '0;
         for (int k = 0; k < NUM_EVENTS; k++) ev_cnt_q[k] <= '0;
      end else if (counted) begin
         cyc_q <= cyc_inc;
         for (int k = 0; k < NUM_EVENTS; k++) begin
            if (event_i[k]) begin
               if (ev_cnt_q[k] == CNT_MAX) begin
                  ovf_q[k] <= 1'b1;
               end else begin
                  ev_cnt_q[k] <= ev_cnt_q[k] + CNT_ONE;
               end
            end
         end
      end
   end

   // Select 0 is the cycle count; out-of-range selects read as zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i <= NUM_EVENTS; i++) begin
         if (sel_i == SEL_W'(i)) rd_val = snap_q[i];
      end
   end

   // NOTE: the snapshot bank is reset explicitly; it is a readable register file,
   // not RAM, and must read 0 after reset or clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_o <= '0;
         for (int i = 0; i <= NUM_EVENTS; i++) snap_q[i] <= '0;
      end else if (clear_i) begin
         count_o <= '0;
         for (int i = 0; i <= NUM_EVENTS; i++) snap_q[i] <= '0;
      end else begin
         if (snap_i) begin
            snap_q[0] <= cyc_q;
            for (int k = 0; k < NUM_EVENTS; k++) snap_q[k+1] <= ev_cnt_q[k];
         end
         count_o <= rd_val;
      end
   end

   assign cycle_o   = cyc_q;
   assign ovf_o     = ovf_q;
   assign running_o = (state_q == S_RUN);
   assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: directed scenarios plus a randomized run
// checked against a small behavioural model of the counting rules.
module tb_perf_monitor;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        start_i, clear_i, snap_i;
   logic [3:0]  event_i;
   logic [2:0]  sel_i;
   logic [31:0] count_o, cycle_o;
   logic [3:0]  ovf_o;
   logic        running_o, done_o;

   logic        s_start, s_clear, s_snap;
   logic [3:0]  s_event;
   logic [2:0]  s_sel;
   logic [7:0]  s_count, s_cycle;
   logic [3:0]  s_ovf;
   logic        s_running, s_done;

   int checks = 0;
   int errors = 0;

   perf_monitor u_dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .start_i   (start_i),
      .clear_i   (clear_i),
      .event_i   (event_i),
      .snap_i    (snap_i),
      .sel_i     (sel_i),
      .count_o   (count_o),
      .cycle_o   (cycle_o),
      .ovf_o     (ovf_o),
      .running_o (running_o),
      .done_o    (done_o)
   );

   perf_monitor #(.NUM_EVENTS(4), .CNT_W(8), .CYCLE_LIMIT(0)) u_sat (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .start_i   (s_start),
      .clear_i   (s_clear),
      .event_i   (s_event),
      .snap_i    (s_snap),
      .sel_i     (s_sel),
      .count_o   (s_count),
      .cycle_o   (s_cycle),
      .ovf_o     (s_ovf),
      .running_o (s_running),
      .done_o    (s_done)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      s_clear = 1'b1;
      tick();
      clear_i = 1'b0;
      s_clear = 1'b0;
   endtask

   task automatic take_snap();
      snap_i = 1'b1;
      tick();
      snap_i = 1'b0;
   endtask

   task automatic read_sel(input logic [2:0] s, output logic [31:0] v);
      sel_i = s;
      tick();
      v = count_o;
   endtask

   task automatic test_reset();
      checks++; if (count_o !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
      checks++; if (cycle_o !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d want 0", cycle_o); end
      checks++; if (ovf_o !== 4'd0) begin errors++; $display("FAIL reset_ovf: got %b want 0000", ovf_o); end
      checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
   endtask

   task automatic test_basic_run();
      int          exp0;
      logic [31:0] v;
      exp0 = 0;
      start_i = 1'b0; event_i = '0;
      do_clear();
      start_i = 1'b1;
      for (int e = 1; e <= 31; e++) begin
         event_i = '0;
         if (e >= 2 && ((e - 2) % 2 == 0)) begin
            event_i[0] = 1'b1;
            exp0++;
         end
         tick();
         if (e == 30) begin
            checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0 after 30 edges", done_o); end
         end
      end
      event_i = '0;
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1 after 31 edges", done_o); end
      checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL basic_running: got %b want 0", running_o); end
      tick();
      checks++; if (cycle_o !== 32'd30) begin errors++; $display("FAIL basic_cycle_hold: got %0d want 30", cycle_o); end
      start_i = 1'b0;
      take_snap();
      read_sel(3'd0, v);
      checks++; if (v !== 32'd30) begin errors++; $display("FAIL basic_sel0: got %0d want 30", v); end
      read_sel(3'd1, v);
      checks++; if (v !== 32'(exp0)) begin errors++; $display("FAIL basic_sel1: got %0d want %0d", v, exp0); end
      read_sel(3'd2, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL basic_sel2: got %0d want 0", v); end
      read_sel(3'd7, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL basic_sel7: got %0d want 0", v); end
   endtask

   task automatic test_pause();
      logic [31:0] v;
      start_i = 1'b0; event_i = '0;
      do_clear();
      start_i = 1'b1;
      event_i = 4'b1111;
      tick();
      for (int i = 0; i < 10; i++) tick();
      checks++; if (cycle_o !== 32'd10) begin errors++; $display("FAIL pause_pre: got %0d want 10", cycle_o); end
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (cycle_o !== 32'd10) begin errors++; $display("FAIL pause_cycle: got %0d want 10", cycle_o); end
      end
      checks++; if (running_o !== 1'b1) begin errors++; $display("FAIL pause_running: got %b want 1", running_o); end
      start_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 19) begin
            checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL pause_done_early: got %b want 0 at edge 35", done_o); end
         end
      end
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL pause_done: got %b want 1 at edge 36", done_o); end
      checks++; if (cycle_o !== 32'd30) begin errors++; $display("FAIL pause_cycle_end: got %0d want 30", cycle_o); end
      start_i = 1'b0; event_i = '0;
      take_snap();
      for (int s = 1; s <= 4; s++) begin
         read_sel(3'(s), v);
         checks++; if (v !== 32'd30) begin errors++; $display("FAIL pause_ch%0d: got %0d want 30", s - 1, v); end
      end
   endtask

   task automatic test_saturation();
      do_clear();
      s_start = 1'b1;
      s_event = 4'b0100;
      tick();
      for (int i = 0; i < 255; i++) tick();
      checks++; if (s_ovf !== 4'b0000) begin errors++; $display("FAIL sat_ovf_early: got %b want 0000", s_ovf); end
      checks++; if (s_cycle !== 8'd255) begin errors++; $display("FAIL sat_cycle255: got %0d want 255", s_cycle); end
      tick();
      checks++; if (s_ovf !== 4'b0100) begin errors++; $display("FAIL sat_ovf_set: got %b want 0100", s_ovf); end
      for (int i = 0; i < 44; i++) tick();
      checks++; if (s_ovf !== 4'b0100) begin errors++; $display("FAIL sat_ovf_sticky: got %b want 0100", s_ovf); end
      checks++; if (s_cycle !== 8'd255) begin errors++; $display("FAIL sat_cycle: got %0d want 255", s_cycle); end
      checks++; if (s_running !== 1'b1 || s_done !== 1'b0) begin errors++; $display("FAIL sat_state: got run=%b done=%b want 1/0", s_running, s_done); end
      s_start = 1'b0; s_event = '0;
      s_snap = 1'b1; tick(); s_snap = 1'b0;
      s_sel = 3'd3; tick();
      checks++; if (s_count !== 8'd255) begin errors++; $display("FAIL sat_ch2: got %0d want 255", s_count); end
      s_sel = 3'd1; tick();
      checks++; if (s_count !== 8'd0) begin errors++; $display("FAIL sat_ch0: got %0d want 0", s_count); end
   endtask

   task automatic test_snap_same_edge();
      logic [31:0] v;
      start_i = 1'b0; event_i = '0;
      do_clear();
      sel_i = 3'd1;
      start_i = 1'b1;
      tick();
      event_i = 4'b0001;
      for (int i = 0; i < 7; i++) tick();
      snap_i = 1'b1;
      tick();
      snap_i = 1'b0; start_i = 1'b0; event_i = '0;
      checks++; if (count_o !== 32'd0) begin errors++; $display("FAIL snap_lat1: got %0d want 0", count_o); end
      tick();
      checks++; if (count_o !== 32'd7) begin errors++; $display("FAIL snap_lat2: got %0d want 7", count_o); end
      checks++; if (cycle_o !== 32'd8) begin errors++; $display("FAIL snap_cycle: got %0d want 8", cycle_o); end
      take_snap();
      read_sel(3'd1, v);
      checks++; if (v !== 32'd8) begin errors++; $display("FAIL snap_live: got %0d want 8", v); end
   endtask

   task automatic test_clear_in_done();
      logic [31:0] v;
      start_i = 1'b0; event_i = '0;
      do_clear();
      start_i = 1'b1;
      for (int i = 0; i < 31; i++) begin
         event_i = 4'($urandom);
         tick();
      end
      event_i = '0;
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL clr_reach_done: got %b want 1", done_o); end
      start_i = 1'b0;
      take_snap();
      read_sel(3'd0, v);
      checks++; if (v !== 32'd30) begin errors++; $display("FAIL clr_pre_read: got %0d want 30", v); end
      snap_i = 1'b1; clear_i = 1'b1;
      tick();
      snap_i = 1'b0; clear_i = 1'b0;
      checks++; if (count_o !== 32'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", count_o); end
      checks++; if (cycle_o !== 32'd0) begin errors++; $display("FAIL clr_cycle: got %0d want 0", cycle_o); end
      checks++; if (ovf_o !== 4'd0) begin errors++; $display("FAIL clr_ovf: got %b want 0000", ovf_o); end
      checks++; if (running_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL clr_state: got run=%b done=%b want 0/0", running_o, done_o); end
      read_sel(3'd0, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL clr_read0: got %0d want 0", v); end
      read_sel(3'd1, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL clr_read1: got %0d want 0", v); end
      // start and clear together in DONE
      start_i = 1'b1;
      for (int i = 0; i < 31; i++) tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      checks++; if (running_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL clr_start_idle: got run=%b done=%b want 0/0", running_o, done_o); end
      tick();
      checks++; if (running_o !== 1'b1) begin errors++; $display("FAIL clr_restart: got run=%b want 1", running_o); end
      tick();
      checks++; if (cycle_o !== 32'd1) begin errors++; $display("FAIL clr_recount: got %0d want 1", cycle_o); end
      start_i = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      start_i = 1'b0; event_i = '0;
      do_clear();
      start_i = 1'b1;
      event_i = 4'b0011;
      tick();
      for (int i = 0; i < 6; i++) tick();
      sel_i = 3'd0;
      snap_i = 1'b1;
      tick();
      snap_i = 1'b0;
      tick();
      checks++; if (count_o !== 32'd6) begin errors++; $display("FAIL rst_pre_count: got %0d want 6", count_o); end
      checks++; if (cycle_o !== 32'd8) begin errors++; $display("FAIL rst_pre_cycle: got %0d want 8", cycle_o); end
      #2;
      rst_n_i = 1'b0;
      #1;
      checks++; if (count_o !== 32'd0 || cycle_o !== 32'd0) begin errors++; $display("FAIL rst_async_cnt: got count=%0d cycle=%0d want 0/0", count_o, cycle_o); end
      checks++; if (running_o !== 1'b0 || ovf_o !== 4'd0) begin errors++; $display("FAIL rst_async_state: got run=%b ovf=%b want 0/0000", running_o, ovf_o); end
      #1;
      rst_n_i = 1'b1;
      tick();
      checks++; if (running_o !== 1'b1 || cycle_o !== 32'd0) begin errors++; $display("FAIL rst_resume: got run=%b cycle=%0d want 1/0", running_o, cycle_o); end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (cycle_o !== 32'd4) begin errors++; $display("FAIL rst_recount: got %0d want 4", cycle_o); end
      start_i = 1'b0; event_i = '0;
      take_snap();
      read_sel(3'd2, v);
      checks++; if (v !== 32'd4) begin errors++; $display("FAIL rst_ch1: got %0d want 4", v); end
   endtask

   task automatic test_random();
      int          m_state;
      int          m_cyc;
      int          m_cnt [4];
      int          expv;
      logic [31:0] v;
      start_i = 1'b0; event_i = '0;
      do_clear();
      m_state = 0;
      m_cyc   = 0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      for (int n = 0; n < 300 && m_state != 2; n++) begin
         start_i = ($urandom_range(0, 3) != 0);
         event_i = 4'($urandom);
         if (m_state == 0 && start_i) begin
            m_state = 1;
         end else if (m_state == 1 && start_i) begin
            m_cyc++;
            for (int k = 0; k < 4; k++) if (event_i[k]) m_cnt[k]++;
            if (m_cyc == 30) m_state = 2;
         end
         tick();
         checks++; if (cycle_o !== 32'(m_cyc)) begin errors++; $display("FAIL rand_cycle: got %0d want %0d", cycle_o, m_cyc); end
         checks++; if (done_o !== (m_state == 2)) begin errors++; $display("FAIL rand_done: got %b want %0d", done_o, m_state == 2); end
      end
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rand_timeout: done got %b want 1 within budget", done_o); end
      start_i = 1'b0; event_i = '0;
      take_snap();
      for (int s = 0; s < 8; s++) begin
         if (s == 0) expv = m_cyc;
         else if (s <= 4) expv = m_cnt[s - 1];
         else expv = 0;
         read_sel(3'(s), v);
         checks++; if (v !== 32'(expv)) begin errors++; $display("FAIL rand_sel%0d: got %0d want %0d", s, v, expv); end
      end
   endtask

   initial begin
      rst_n_i = 1'b0;
      start_i = 1'b0; clear_i = 1'b0; snap_i = 1'b0; event_i = '0; sel_i = '0;
      s_start = 1'b0; s_clear = 1'b0; s_snap = 1'b0; s_event = '0; s_sel = '0;
      #12;
      test_reset();
      rst_n_i = 1'b1;
      tick();
      test_basic_run();
      test_pause();
      test_saturation();
      test_snap_same_edge();
      test_clear_in_done();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable, parametrised pipeline event monitor for the CPU. It counts cycles and up to NUM_EVENTS per-cycle event strobes, such as the hazard unit's stall select and the IF/ID flush. Counters saturate with sticky overflow flags, and the block declares a run finished after a programmable cycle limit. It sits beside the CPU top level, with event inputs wired from pipeline control signals. Results are read through an atomic snapshot and select port, so silicon exposes the same stall/flush statistics the simulation bench collects.

## Interface
Parameters:
- NUM_EVENTS, 4, number of event channels (1..16)
- CNT_W, 32, width of every counter, cycle counter included (8..32)
- CYCLE_LIMIT, 30, counted cycles before DONE; 0 means unlimited

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- start_i  input  1  run enable; counting occurs only while high
- clear_i  input  1  synchronous clear of counters, flags and snapshot; return to IDLE
- event_i  input  NUM_EVENTS  per-cycle event strobes, bit k = channel k
- snap_i  input  1  capture all live counters into snapshot registers
- sel_i  input  clog2(NUM_EVENTS+1)  readout select: 0 = cycle count, k = channel k-1
- count_o  output  CNT_W  registered snapshot value chosen by sel_i
- cycle_o  output  CNT_W  live cycle counter
- ovf_o  output  NUM_EVENTS  sticky per-channel saturation flags
- running_o  output  1  high in RUN
- done_o  output  1  high in DONE

## Operation
- States:
  - IDLE: entered at reset or clear.
  - RUN: entered when start_i is sampled 1 in IDLE.
  - DONE: entered when the cycle limit is reached. It is held until clear_i or reset.
- A counted edge is any rising edge with state == RUN and start_i == 1.
  - If start_i drops in RUN, counting pauses and the state stays RUN.
- On each counted edge:
  - The cycle counter increments by 1.
  - Each channel counter k with event_i[k] == 1 increments by 1.
- Saturation: a counter at 2^CNT_W-1 holds its value. If channel k saturates while its event is high, ovf_o[k] is set and stays set until clear or reset. The cycle counter saturates silently.
- Limit: if CYCLE_LIMIT != 0 and the incremented cycle value equals CYCLE_LIMIT, the state goes to DONE on that same edge. Events on that edge are counted. No counting occurs in DONE.
- Snapshot: on an edge with snap_i == 1, every snapshot register loads the live counter value present before that edge's increment. snap_i is honoured in every state.
- Readout: count_o <= snapshot[sel_i] on every edge. sel_i > NUM_EVENTS yields 0.
- Priority: rst_n_i > clear_i > snap_i / counting. clear_i forces state IDLE and zeroes all counters, snapshot registers, ovf_o and count_o. A snap_i in the same cycle as clear_i is ignored.

## Timing
- Reset values: count_o = 0, cycle_o = 0, ovf_o = 0, running_o = 0, done_o = 0, state IDLE, all counters and snapshots 0.
- Reset is asynchronous mid-run: outputs go to reset values immediately on rst_n_i falling. Operation resumes from IDLE on the first edge after release.
- IDLE→RUN costs one edge that is not counted. The first counted edge is the next edge with start_i == 1.
- cycle_o, running_o and done_o update on the edge and are visible in the following cycle.
- count_o latency:
  - 1 cycle from a sel_i change.
  - 2 cycles from snap_i to the new value appearing on count_o (snapshot edge, then readout edge).
- With start_i held high from IDLE, done_o rises after exactly CYCLE_LIMIT+1 edges, and cycle_o = CYCLE_LIMIT thereafter.
- When start_i and clear_i are both high in DONE or RUN, the block goes to IDLE. It re-enters RUN on a later edge if start_i is still high.

## Test plan
- Default parameters, start_i held high, event_i[0] high on alternate counted cycles, event_i[1] never -> done_o rises after 31 edges; cycle = 30, ch0 = 15, ch1 = 0 read via snap_i and sel_i = 0/1/2.
- Pause: start_i low for 5 cycles mid-run with event_i = 4'b1111 throughout -> no counter advances during the pause; done_o is delayed by exactly 5 cycles.
- Saturation with CNT_W = 8, CYCLE_LIMIT = 0, event_i[2] high for 300 counted cycles -> ch2 = 255, ovf_o = 4'b0100, cycle = 255 with no ovf bit.
- Snap on the same edge as event increments: live ch0 = 7 with event_i[0] high -> the snapshot reads 7; live becomes 8; count_o = 7 two cycles after snap_i.
- clear_i and snap_i together in DONE -> all outputs 0, state IDLE; count_o = 0 on the next read.
- rst_n_i pulsed low mid-run between edges -> outputs read 0 before the next edge; normal counting restarts after release.
